// File: rtl/bcd_serial_adder_seq.sv
// Digit-serial sequencer that walks packed-BCD operands LSD-first through one external digit adder.
// Optional macro BCD_DIGIT_CHECK_EN adds an err output flagging non-BCD operand digits.
module bcd_serial_adder_seq #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  input  logic                cin,
  output logic [3:0]          add_a,
  output logic [3:0]          add_b,
  output logic                add_cin,
  input  logic [3:0]          add_s,
  input  logic                add_cout,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] sum,
  output logic                cout
`ifdef BCD_DIGIT_CHECK_EN
  ,
  output logic                err
`endif
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t              state_reg;
  logic [4*DIGITS-1:0] a_reg;
  logic [4*DIGITS-1:0] b_reg;
  logic [IW-1:0]       idx_reg;
  logic [IW-1:0]       idx_next;
  logic [3:0]          a_dig [DIGITS];
  logic [3:0]          b_dig [DIGITS];
  logic [3:0]          a_next_dig;
  logic [3:0]          b_next_dig;

  assign idx_next = idx_reg + 1'b1;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_dig
      assign a_dig[gi] = a_reg[4*gi +: 4];
      assign b_dig[gi] = b_reg[4*gi +: 4];
    end
  endgenerate

  // Digits presented on the next RUN cycle; add_a/add_b are registered so they are stable all cycle.
  always_comb begin
    a_next_dig = 4'd0;
    b_next_dig = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_next == IW'(i)) begin
        a_next_dig = a_dig[i];
        b_next_dig = b_dig[i];
      end
    end
  end

`ifdef BCD_DIGIT_CHECK_EN
  logic [DIGITS-1:0] dig_bad;
  logic              bad_digit;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_chk
      assign dig_bad[gi] = (a_dig[gi] > 4'd9) || (b_dig[gi] > 4'd9);
    end
  endgenerate

  assign bad_digit = |dig_bad;
`endif

  // add_cin doubles as the running decimal carry between digits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      idx_reg   <= '0;
      add_a     <= 4'd0;
      add_b     <= 4'd0;
      add_cin   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
`ifdef BCD_DIGIT_CHECK_EN
      err       <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_reg     <= a;
            b_reg     <= b;
            add_a     <= a[3:0];
            add_b     <= b[3:0];
            add_cin   <= cin;
            sum       <= '0;
            cout      <= 1'b0;
            idx_reg   <= '0;
            busy      <= 1'b1;
`ifdef BCD_DIGIT_CHECK_EN
            err       <= 1'b0;
`endif
            state_reg <= RUN;
          end
        end

        RUN: begin
          for (int i = 0; i < DIGITS; i++) begin
            if (idx_reg == IW'(i)) begin
              sum[4*i +: 4] <= add_s;
            end
          end
          if (idx_reg == LAST_IDX) begin
            cout      <= add_cout;
            add_a     <= 4'd0;
            add_b     <= 4'd0;
            add_cin   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
`ifdef BCD_DIGIT_CHECK_EN
            err       <= bad_digit;
`endif
            state_reg <= DONE;
          end else begin
            add_a   <= a_next_dig;
            add_b   <= b_next_dig;
            add_cin <= add_cout;
            idx_reg <= idx_next;
          end
        end

        DONE: begin
          done      <= 1'b0;
          state_reg <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_serial_adder_seq.sv
// Self-checking bench: decimal-arithmetic model compared every cycle, plus directed literal checks.
module tb_bcd_serial_adder_seq;

  localparam int D = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [15:0]   a, b;
  logic          cin;
  logic [3:0]    add_a, add_b, add_s;
  logic          add_cin, add_cout;
  logic          busy, done, cout;
  logic [15:0]   sum;
`ifdef BCD_DIGIT_CHECK_EN
  logic          err;
`endif

  logic          start1;
  logic [3:0]    a1, b1, add_a1, add_b1, add_s1, sum1;
  logic          cin1, add_cin1, add_cout1, busy1, done1, cout1;
`ifdef BCD_DIGIT_CHECK_EN
  logic          err1;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bcd_serial_adder_seq #(.DIGITS(D)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_s(add_s), .add_cout(add_cout),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
`ifdef BCD_DIGIT_CHECK_EN
    , .err(err)
`endif
  );

  bcd_serial_adder_seq #(.DIGITS(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .add_a(add_a1), .add_b(add_b1), .add_cin(add_cin1), .add_s(add_s1), .add_cout(add_cout1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
`ifdef BCD_DIGIT_CHECK_EN
    , .err(err1)
`endif
  );

  // Behavioural single-digit BCD adder standing in for the downstream block.
  function automatic logic [4:0] digit_add(input logic [3:0] x, input logic [3:0] y, input logic c);
    int t;
    t = int'(x) + int'(y) + int'(c);
    if (t > 9) return {1'b1, 4'(t - 10)};
    return {1'b0, 4'(t)};
  endfunction

  assign {add_cout, add_s}   = digit_add(add_a, add_b, add_cin);
  assign {add_cout1, add_s1} = digit_add(add_a1, add_b1, add_cin1);

  function automatic int dec(input logic [15:0] v);
    int r = 0;
    for (int i = D - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [15:0] enc(input int v);
    logic [15:0] r = '0;
    int t = v;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int pow10(input int k);
    int r = 1;
    for (int i = 0; i < k; i++) r = r * 10;
    return r;
  endfunction

  function automatic bit bcd_ok(input logic [15:0] v);
    for (int i = 0; i < D; i++) if (v[4*i +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  // Decimal sum of the low k digits of both operands plus carry-in.
  function automatic int part(input logic [15:0] x, input logic [15:0] y, input logic c, input int k);
    return dec(x) % pow10(k) + dec(y) % pow10(k) + int'(c);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: m_cnt = 0 idle, 1..D working on digit m_cnt-1, D+1 result cycle.
  int          m_cnt   = 0;
  logic [15:0] m_a     = '0;
  logic [15:0] m_b     = '0;
  logic        m_cin   = 1'b0;
  logic        m_valid = 1'b1;
  logic [15:0] m_sum   = '0;
  logic        m_cout  = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt   <= 0;
      m_sum   <= '0;
      m_cout  <= 1'b0;
      m_valid <= 1'b1;
    end else if (m_cnt == 0) begin
      if (start) begin
        m_a     <= a;
        m_b     <= b;
        m_cin   <= cin;
        m_valid <= bcd_ok(a) && bcd_ok(b);
        m_sum   <= '0;
        m_cout  <= 1'b0;
        m_cnt   <= 1;
      end
    end else if (m_cnt <= D) begin
      m_sum <= enc(part(m_a, m_b, m_cin, m_cnt) % pow10(m_cnt));
      if (m_cnt == D) m_cout <= (part(m_a, m_b, m_cin, D) >= pow10(D));
      m_cnt <= m_cnt + 1;
    end else begin
      m_cnt <= 0;
    end
  end

  int cj;
  always @(negedge clk) begin
    chk("busy", 32'(busy), 32'(m_cnt >= 1 && m_cnt <= D));
    chk("done", 32'(done), 32'(m_cnt == D + 1));
    if (m_cnt >= 1 && m_cnt <= D) begin
      cj = m_cnt - 1;
      chk("add_a", 32'(add_a), 32'(m_a[4*cj +: 4]));
      chk("add_b", 32'(add_b), 32'(m_b[4*cj +: 4]));
      if (m_valid) chk("add_cin", 32'(add_cin), 32'(part(m_a, m_b, m_cin, cj) >= pow10(cj)));
    end else begin
      chk("add_a_idle", 32'(add_a), 32'd0);
      chk("add_b_idle", 32'(add_b), 32'd0);
      chk("add_cin_idle", 32'(add_cin), 32'd0);
    end
    if (m_valid) begin
      chk("sum", 32'(sum), 32'(m_sum));
      chk("cout", 32'(cout), 32'(m_cout));
    end
  end

  task automatic run_op(input logic [15:0] x, input logic [15:0] y, input logic c, output int lat);
    @(negedge clk);
    a = x; b = y; cin = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!done) chk("done_timeout", 32'(done), 32'd1);
    $display("op %h + %h + %0d -> sum %h cout %0d after %0d cycles", x, y, c, sum, cout, lat);
  endtask

  int lat;
  int pulses;
  logic [15:0] held_sum;

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_add_a", 32'(add_a), 32'd0);
    rst = 1'b0;

    run_op(16'h1234, 16'h8766, 1'b0, lat);
    chk("lat_1234", 32'(lat), 32'd5);
    chk("sum_1234", 32'(sum), 32'h0000);
    chk("cout_1234", 32'(cout), 32'd1);

    run_op(16'h9999, 16'h0000, 1'b1, lat);
    chk("sum_9999", 32'(sum), 32'h0000);
    chk("cout_9999", 32'(cout), 32'd1);

    run_op(16'h0045, 16'h0038, 1'b0, lat);
    chk("sum_45_38", 32'(sum), 32'h0083);
    chk("cout_45_38", 32'(cout), 32'd0);

    run_op(16'h0999, 16'h0001, 1'b0, lat);
    chk("sum_0999", 32'(sum), 32'h1000);

    // Start pulsed again two cycles into RUN must be ignored.
    @(negedge clk);
    a = 16'h0100; b = 16'h0200; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 16'h5555; b = 16'h4444; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pulses = 0; held_sum = '0;
    for (int i = 0; i < 10; i++) begin
      if (done) begin
        pulses++;
        held_sum = sum;
      end
      @(negedge clk);
    end
    $display("op 0100 + 0200 with late start -> sum %h done pulses %0d", held_sum, pulses);
    chk("ignore_pulses", 32'(pulses), 32'd1);
    chk("ignore_sum", 32'(held_sum), 32'h0300);

    // Reset in the middle of a run discards the partial result.
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_sum", 32'(sum), 32'd0);
    chk("midrst_add_a", 32'(add_a), 32'd0);
    $display("op 1111 + 2222 aborted by reset -> busy %0d sum %h", busy, sum);
    @(negedge clk);
    rst = 1'b0;
    run_op(16'h0500, 16'h0501, 1'b1, lat);
    chk("after_rst_sum", 32'(sum), 32'h1002);
    chk("after_rst_lat", 32'(lat), 32'd5);

    run_op(16'h5000, 16'h5000, 1'b0, lat);
    chk("sum_5000", 32'(sum), 32'h0000);
    chk("cout_5000", 32'(cout), 32'd1);

    // Single-digit instance.
    @(negedge clk);
    a1 = 4'h7; b1 = 4'h5; cin1 = 1'b0; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    chk("d1_add_a", 32'(add_a1), 32'd7);
    chk("d1_add_b", 32'(add_b1), 32'd5);
    chk("d1_busy", 32'(busy1), 32'd1);
    chk("d1_done_early", 32'(done1), 32'd0);
    @(negedge clk);
    chk("d1_done", 32'(done1), 32'd1);
    chk("d1_sum", 32'(sum1), 32'h2);
    chk("d1_cout", 32'(cout1), 32'd1);
    chk("d1_add_a_done", 32'(add_a1), 32'd0);
    $display("op d1 7 + 5 -> sum %h cout %0d", sum1, cout1);
    @(negedge clk);
    chk("d1_done_once", 32'(done1), 32'd0);

`ifdef BCD_DIGIT_CHECK_EN
    run_op(16'h00A0, 16'h0001, 1'b0, lat);
    chk("err_set", 32'(err), 32'd1);
    run_op(16'h0001, 16'h0001, 1'b0, lat);
    chk("err_clear", 32'(err), 32'd0);
    chk("err_clear_sum", 32'(sum), 32'h0002);
`endif

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
